// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine feeding the HI/LO register pair.
// Computes one product or quotient bit per cycle; MTHI/MTLO pass straight through.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic [WIDTH-1:0] HiData,
    output logic [WIDTH-1:0] LoData,
    output logic             HIWrite,
    output logic             LOWrite,
    output logic             DivZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             div_q, neg_q, neg_r;
    logic [WIDTH-1:0] hi_q, lo_q, b_q;

    logic             op_signed, a_neg, b_neg, accept;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   sum, shifted, diff;
    logic [WIDTH-1:0] hi_n, lo_n, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod;

    assign op_signed = ~Op[0];
    assign a_neg     = op_signed & OpA[WIDTH-1];
    assign b_neg     = op_signed & OpB[WIDTH-1];
    assign abs_a     = a_neg ? -OpA : OpA;
    assign abs_b     = b_neg ? -OpB : OpB;
    assign accept    = (state == IDLE) && Start;
    assign Busy      = (state != IDLE);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        hi_n    = hi_q;
        lo_n    = lo_q;
        prod    = '0;
        fin_hi  = '0;
        fin_lo  = '0;
        if (div_q) begin
            // Restoring step: keep the trial subtraction only if it did not borrow.
            shifted = {hi_q, lo_q[WIDTH-1]};
            diff    = shifted - {1'b0, b_q};
            if (!diff[WIDTH]) begin
                hi_n = diff[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = shifted[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
            fin_lo = neg_q ? -lo_n : lo_n;
            fin_hi = neg_r ? -hi_n : hi_n;
        end else begin
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo_q[WIDTH-1:1]};
            prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    // NOTE: working registers are not reset; they are always loaded on accept before use.
    always_ff @(posedge Clk) begin
        if (accept) begin
            div_q <= Op[1];
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (Op[1]) begin
                hi_q <= '0;
                lo_q <= abs_a;
                b_q  <= abs_b;
            end else begin
                hi_q <= '0;
                lo_q <= abs_b;
                b_q  <= abs_a;
            end
        end else if (state == RUN) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            count   <= '0;
            HiData  <= '0;
            LoData  <= '0;
            HIWrite <= 1'b0;
            LOWrite <= 1'b0;
            DivZero <= 1'b0;
        end else begin
            HIWrite <= 1'b0;
            LOWrite <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (!Op[2]) begin
                            if (Op[1] && (OpB == '0)) begin
                                HiData  <= OpA;
                                LoData  <= '1;
                                HIWrite <= 1'b1;
                                LOWrite <= 1'b1;
                                DivZero <= 1'b1;
                                state   <= FINISH;
                            end else begin
                                count <= '0;
                                state <= RUN;
                            end
                        end else if (Op[1:0] == 2'b00) begin
                            HiData  <= OpA;
                            HIWrite <= 1'b1;
                            state   <= FINISH;
                        end else if (Op[1:0] == 2'b01) begin
                            LoData  <= OpA;
                            LOWrite <= 1'b1;
                            state   <= FINISH;
                        end
                    end
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        HiData  <= fin_hi;
                        LoData  <= fin_lo;
                        HIWrite <= 1'b1;
                        LOWrite <= 1'b1;
                        state   <= FINISH;
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
